// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================
// match_pkg : shared state encodings and width/slice helpers
// Rev 1.0
// ============================================================
package match_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PLAYING   = 3'd1;
    localparam logic [2:0] S_PAUSED    = 3'd2;
    localparam logic [2:0] S_GOAL_HOLD = 3'd3;
    localparam logic [2:0] S_OVER      = 3'd4;
    localparam logic [2:0] S_OVERTIME  = 3'd5;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int score_lo(input int team, input int width);
        return team * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_controller_if.sv
`default_nettype none
// ============================================================
// match_controller_if : user/ball inputs and display-path outputs
// Rev 1.0
// ============================================================
interface match_controller_if
    import match_pkg::*;
#(
    parameter int NUM_TEAMS     = 2,
    parameter int SCORE_WIDTH   = 4,
    parameter int MATCH_SECONDS = 180
);
    localparam int TIME_W = clog2_min1(MATCH_SECONDS + 1);
    localparam int WIN_W  = clog2_min1(NUM_TEAMS);

    logic                             start_pulse;
    logic                             pause_pulse;
    logic [NUM_TEAMS-1:0]             goal_valid;
    logic [TIME_W-1:0]                time_left;
    logic [NUM_TEAMS*SCORE_WIDTH-1:0] scores;
    logic [2:0]                       state;
    logic                             game_on;
    logic                             game_over;
    logic                             ball_reset;
    logic                             sec_tick;
    logic [WIN_W-1:0]                 winner;
    logic                             draw;

    modport master (
        output start_pulse, pause_pulse, goal_valid,
        input  time_left, scores, state, game_on, game_over,
               ball_reset, sec_tick, winner, draw
    );

    modport slave (
        input  start_pulse, pause_pulse, goal_valid,
        output time_left, scores, state, game_on, game_over,
               ball_reset, sec_tick, winner, draw
    );

endinterface
`default_nettype wire

// File: rtl/sec_prescaler.sv
`default_nettype none
// ============================================================
// sec_prescaler : modulo-DIV cycle counter with one-cycle wrap tick
// Rev 1.0
// ============================================================
module sec_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (DIV <= 1) begin : g_passthru
            // Degenerate divider: every enabled cycle is a wrap.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr};
            assign tick     = en;
        end else begin : g_count
            localparam int             CW     = $clog2(DIV);
            localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = (cnt_q == c_last) ? '0 : cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick = en && !clr && (cnt_q == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================
// match_controller : match FSM, countdown clock, per-team scores
// Rev 1.0 | option macro: MATCH_CONTROLLER_GOLDEN_GOAL_EN
// ============================================================
module match_controller
    import match_pkg::*;
#(
    parameter int CLK_FREQ_HZ       = 50000000,
    parameter int MATCH_SECONDS     = 180,
    parameter int NUM_TEAMS         = 2,
    parameter int SCORE_WIDTH       = 4,
    parameter int WIN_SCORE         = 7,
    parameter int GOAL_HOLD_SECONDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    match_controller_if.slave bus
);

    localparam int                TIME_W      = clog2_min1(MATCH_SECONDS + 1);
    localparam int                WIN_W       = clog2_min1(NUM_TEAMS);
    localparam logic [TIME_W-1:0] c_time_init = TIME_W'(MATCH_SECONDS);
    localparam logic [31:0]       c_win_score = WIN_SCORE;

    logic [2:0]             state_q, state_d;
    logic [TIME_W-1:0]      time_q, time_d;
    logic [SCORE_WIDTH-1:0] score_q [NUM_TEAMS];
    logic [SCORE_WIDTH-1:0] score_d [NUM_TEAMS];
    logic [WIN_W-1:0]       winner_q, winner_d;
    logic                   draw_q, draw_d;
    logic                   ball_reset_q, ball_reset_d;
    logic                   sec_tick_q, sec_tick_d;

    logic [SCORE_WIDTH-1:0]           w_credit [NUM_TEAMS];
    logic [SCORE_WIDTH-1:0]           w_max;
    logic [WIN_W-1:0]                 w_winner;
    logic                             w_draw, w_win_hit, w_any_goal;
    logic                             w_sec_wrap, w_hold_done;
    logic [NUM_TEAMS*SCORE_WIDTH-1:0] w_scores;

    // The second prescaler only clears from IDLE, so pause and goal hold
    // both resume mid-second.
    sec_prescaler #(.DIV(CLK_FREQ_HZ)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_PLAYING),
        .clr  (state_q == S_IDLE),
        .tick (w_sec_wrap)
    );

    sec_prescaler #(.DIV(GOAL_HOLD_SECONDS * CLK_FREQ_HZ)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_GOAL_HOLD),
        .clr  (state_q != S_GOAL_HOLD),
        .tick (w_hold_done)
    );

    assign w_any_goal = |bus.goal_valid;

    // Scores as they would stand after crediting this cycle's goals, plus
    // the ranking of that outcome.
    always_comb begin
        w_max     = '0;
        w_winner  = '0;
        w_draw    = 1'b0;
        w_win_hit = 1'b0;
        for (int i = 0; i < NUM_TEAMS; i++) begin
            w_credit[i] = score_q[i];
            if (bus.goal_valid[i] && (score_q[i] != '1)) begin
                w_credit[i] = score_q[i] + 1'b1;
            end
            if (w_credit[i] > w_max) begin
                w_max    = w_credit[i];
                w_winner = WIN_W'(i);
            end
            if ((c_win_score != 0) && (32'(w_credit[i]) >= c_win_score)) begin
                w_win_hit = 1'b1;
            end
        end
        for (int i = 0; i < NUM_TEAMS; i++) begin
            if ((w_credit[i] == w_max) && (WIN_W'(i) != w_winner)) begin
                w_draw = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        score_d      = score_q;
        winner_d     = winner_q;
        draw_d       = draw_q;
        ball_reset_d = 1'b0;
        sec_tick_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_pulse) state_d = S_PLAYING;
            end
            S_PLAYING: begin
                if (w_sec_wrap && (time_q != '0)) begin
                    time_d     = time_q - 1'b1;
                    sec_tick_d = 1'b1;
                end
                if (w_any_goal) score_d = w_credit;
                if (w_any_goal && w_win_hit) begin
                    state_d = S_OVER;
                end else if (w_sec_wrap && (time_q <= TIME_W'(1))) begin
`ifdef MATCH_CONTROLLER_GOLDEN_GOAL_EN
                    state_d = w_draw ? S_OVERTIME : S_OVER;
`else
                    state_d = S_OVER;
`endif
                end else if (w_any_goal) begin
                    state_d      = S_GOAL_HOLD;
                    ball_reset_d = 1'b1;
                end else if (bus.pause_pulse) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (bus.pause_pulse) state_d = S_PLAYING;
            end
            S_GOAL_HOLD: begin
                if (w_hold_done) state_d = S_PLAYING;
            end
            S_OVER: begin
                if (bus.start_pulse) begin
                    state_d  = S_IDLE;
                    time_d   = c_time_init;
                    score_d  = '{default: '0};
                    winner_d = '0;
                    draw_d   = 1'b0;
                end
            end
`ifdef MATCH_CONTROLLER_GOLDEN_GOAL_EN
            S_OVERTIME: begin
                if (w_any_goal) begin
                    score_d = w_credit;
                    if (w_draw) ball_reset_d = 1'b1;
                    else        state_d      = S_OVER;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Result is captured once, on the cycle the match enters OVER.
        if ((state_d == S_OVER) && (state_q != S_OVER)) begin
            winner_d = w_winner;
            draw_d   = w_draw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            time_q       <= c_time_init;
            score_q      <= '{default: '0};
            winner_q     <= '0;
            draw_q       <= 1'b0;
            ball_reset_q <= 1'b0;
            sec_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            score_q      <= score_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            ball_reset_q <= ball_reset_d;
            sec_tick_q   <= sec_tick_d;
        end
    end

    always_comb begin
        w_scores = '0;
        for (int i = 0; i < NUM_TEAMS; i++) begin
            w_scores[score_lo(i, SCORE_WIDTH) +: SCORE_WIDTH] = score_q[i];
        end
    end

    assign bus.scores     = w_scores;
    assign bus.time_left  = time_q;
    assign bus.state      = state_q;
    assign bus.game_on    = (state_q == S_PLAYING);
    assign bus.game_over  = (state_q == S_OVER);
    assign bus.ball_reset = ball_reset_q;
    assign bus.sec_tick   = sec_tick_q;
    assign bus.winner     = winner_q;
    assign bus.draw       = draw_q;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================
// tb_match_controller : scoreboard bench with a behavioural match model
// Rev 1.0
// ============================================================
module tb_match_controller;

    localparam int CLK_HZ   = 4;
    localparam int SECS     = 3;
    localparam int TEAMS    = 2;
    localparam int SW       = 3;
    localparam int WIN      = 3;
    localparam int HOLD_S   = 1;
    localparam int HOLD_CYC = (HOLD_S * CLK_HZ < 1) ? 1 : HOLD_S * CLK_HZ;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    match_controller_if #(.NUM_TEAMS(TEAMS), .SCORE_WIDTH(SW), .MATCH_SECONDS(SECS)) bus ();

    match_controller #(
        .CLK_FREQ_HZ(CLK_HZ), .MATCH_SECONDS(SECS), .NUM_TEAMS(TEAMS),
        .SCORE_WIDTH(SW), .WIN_SCORE(WIN), .GOAL_HOLD_SECONDS(HOLD_S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] tl;
        logic [2:0] s1;
        logic [2:0] s0;
        logic       on;
        logic       over;
        logic       ball;
        logic       tick;
        logic       win;
        logic       draw;
    } snap_t;

    snap_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Match model: modes 0 idle, 1 playing, 2 paused, 3 hold, 4 over, 5 overtime.
    int m_state, m_time, m_sub, m_hold, m_winner, m_draw, m_ball, m_tick;
    int m_score[TEAMS];

    function automatic int top_score();
        int m = 0;
        foreach (m_score[i]) if (m_score[i] > m) m = m_score[i];
        return m;
    endfunction

    function automatic bit tied();
        int n = 0;
        int m = top_score();
        foreach (m_score[i]) if (m_score[i] == m) n++;
        return n >= 2;
    endfunction

    task automatic settle_over();
        m_state  = 4;
        m_draw   = tied() ? 1 : 0;
        m_winner = 0;
        for (int i = TEAMS - 1; i >= 0; i--) if (m_score[i] == top_score()) m_winner = i;
    endtask

    task automatic credit(input bit [TEAMS-1:0] g);
        for (int i = 0; i < TEAMS; i++) if (g[i] && m_score[i] < (1 << SW) - 1) m_score[i]++;
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit [TEAMS-1:0] g);
        bit sec_done, expired, scored, won;
        m_ball = 0;
        m_tick = 0;
        if (r) begin
            m_state = 0; m_time = SECS; m_sub = 0; m_hold = 0; m_winner = 0; m_draw = 0;
            foreach (m_score[i]) m_score[i] = 0;
        end else begin
            case (m_state)
                0: if (s) begin m_state = 1; m_sub = 0; end
                1: begin
                    sec_done = (m_sub == CLK_HZ - 1);
                    m_sub    = sec_done ? 0 : m_sub + 1;
                    expired  = 1'b0;
                    if (sec_done && m_time > 0) begin
                        m_time--;
                        m_tick  = 1;
                        expired = (m_time == 0);
                    end
                    scored = (g != 0);
                    if (scored) credit(g);
                    won = scored && (WIN != 0) && (top_score() >= WIN);
                    if (won) settle_over();
                    else if (expired) begin
`ifdef MATCH_CONTROLLER_GOLDEN_GOAL_EN
                        if (tied()) m_state = 5;
                        else        settle_over();
`else
                        settle_over();
`endif
                    end
                    else if (scored) begin m_state = 3; m_hold = HOLD_CYC; m_ball = 1; end
                    else if (p) m_state = 2;
                end
                2: if (p) m_state = 1;
                3: begin
                    m_hold--;
                    if (m_hold <= 0) m_state = 1;
                end
                4: if (s) begin
                    m_state = 0; m_time = SECS; m_winner = 0; m_draw = 0;
                    foreach (m_score[i]) m_score[i] = 0;
                end
                5: if (g != 0) begin
                    credit(g);
                    if (tied()) m_ball = 1;
                    else        settle_over();
                end
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic snap_t model_snap();
        snap_t e;
        e.state = 3'(m_state);
        e.tl    = 2'(m_time);
        e.s1    = 3'(m_score[1]);
        e.s0    = 3'(m_score[0]);
        e.on    = (m_state == 1);
        e.over  = (m_state == 4);
        e.ball  = (m_ball != 0);
        e.tick  = (m_tick != 0);
        e.win   = 1'(m_winner);
        e.draw  = (m_draw != 0);
        return e;
    endfunction

    task automatic cyc(input bit r, input bit s, input bit p, input bit [1:0] g);
        @(negedge clk);
        rst             = r;
        bus.start_pulse = s;
        bus.pause_pulse = p;
        bus.goal_valid  = g;
        model_step(r, s, p, g);
        exp_q.push_back(model_snap());
    endtask

    // Monitor: every registered output update is compared to the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e;
                snap_t a;
                e = exp_q.pop_front();
                a = {bus.state, bus.time_left, bus.scores, bus.game_on, bus.game_over,
                     bus.ball_reset, bus.sec_tick, bus.winner, bus.draw};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    if (miscompares <= 20)
                        $display("FAIL outputs vec %0d t=%0t: got st=%0d tl=%0d s1=%0d s0=%0d on=%b ov=%b br=%b tk=%b w=%0d d=%b, required st=%0d tl=%0d s1=%0d s0=%0d on=%b ov=%b br=%b tk=%b w=%0d d=%b",
                                 vectors, $time, a.state, a.tl, a.s1, a.s0, a.on, a.over, a.ball, a.tick, a.win, a.draw,
                                 e.state, e.tl, e.s1, e.s0, e.on, e.over, e.ball, e.tick, e.win, e.draw);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.start_pulse = 1'b0;
        bus.pause_pulse = 1'b0;
        bus.goal_valid  = '0;

        cyc(1, 0, 0, 2'b00);
        cyc(1, 0, 0, 2'b00);
        // Full countdown with no goals, then restart.
        cyc(0, 1, 0, 2'b00);
        repeat (15) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        // Goal path followed by win-by-score for team 0.
        cyc(0, 1, 0, 2'b00);
        cyc(0, 0, 0, 2'b10);
        repeat (4) cyc(0, 0, 0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 2'b01);
            repeat (4) cyc(0, 0, 0, 2'b00);
        end
        cyc(0, 1, 0, 2'b00);
        // Pause at prescaler 2, long freeze, resume.
        cyc(0, 1, 0, 2'b00);
        cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 1, 2'b00);
        repeat (20) cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 1, 2'b00);
        repeat (16) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        // Double goal on the final wrap cycle.
        cyc(0, 1, 0, 2'b00);
        repeat (11) cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 0, 2'b11);
        repeat (3) cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 0, 2'b01);
        repeat (2) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        // Reset in the middle of a goal hold.
        cyc(0, 1, 0, 2'b00);
        cyc(0, 0, 0, 2'b01);
        cyc(0, 0, 0, 2'b00);
        cyc(1, 0, 0, 2'b00);
        repeat (3) cyc(0, 0, 0, 2'b00);

        for (int seg = 0; seg < 40; seg++) begin
            int gden;
            case ($urandom_range(0, 2))
                0:       gden = 0;
                1:       gden = 25;
                default: gden = 6;
            endcase
            for (int c = 0; c < 80; c++) begin
                bit [1:0] g;
                for (int b = 0; b < 2; b++)
                    g[b] = (gden != 0) && ($urandom_range(0, gden - 1) == 0);
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0, g);
            end
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised successor to the two-team game timer/score block.
- Owns the match state machine, the countdown clock and the per-team score counters for NUM_TEAMS teams.
- Consumes goal pulses from the ball controller and user start/pause pulses; drives game_on/game_over, the ball re-centre request and the final result to the display path.
- Adds synchronous reset, pause, a post-goal hold, win-by-score and an encoded winner/draw result.

Parameters:
- CLK_FREQ_HZ, 50000000, clk cycles per game second (prescaler terminal count + 1).
- MATCH_SECONDS, 180, countdown start value.
- NUM_TEAMS, 2, number of teams; range 2..8.
- SCORE_WIDTH, 4, bits per team score counter.
- WIN_SCORE, 7, score that ends the match immediately; 0 disables win-by-score.
- GOAL_HOLD_SECONDS, 2, game seconds frozen after each goal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_pulse  in  1  one-cycle start/restart request (already debounced).
- pause_pulse  in  1  one-cycle pause toggle.
- goal_valid  in  NUM_TEAMS  one-cycle goal pulses; bit i credits team i.
- time_left  out  TIME_W  remaining seconds; TIME_W = clog2(MATCH_SECONDS+1).
- scores  out  NUM_TEAMS*SCORE_WIDTH  packed scores; team i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH].
- state  out  3  current FSM state encoding.
- game_on  out  1  high only in PLAYING.
- game_over  out  1  high only in OVER.
- ball_reset  out  1  one-cycle pulse requesting ball re-centre.
- sec_tick  out  1  one-cycle pulse on each countdown decrement.
- winner  out  clog2(NUM_TEAMS)  winning team index; valid only in OVER.
- draw  out  1  tie at maximum score; valid only in OVER.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, time_left=MATCH_SECONDS, scores=0, prescaler=0, hold counter=0.
  - All pulse outputs=0; winner=0; draw=0.
  - Reset wins over every other input in the same cycle.
- States: IDLE=0, PLAYING=1, PAUSED=2, GOAL_HOLD=3, OVER=4, OVERTIME=5 (OVERTIME exists only with the macro).
- IDLE:
  - start_pulse -> PLAYING next cycle.
  - Prescaler is cleared on entry to PLAYING.
  - goal_valid and pause_pulse are ignored.
- PLAYING, prescaler:
  - Counts 0..CLK_FREQ_HZ-1.
  - On wrap, time_left decrements and sec_tick pulses in the same cycle as the registered decrement.
  - If time_left becomes 0 -> OVER.
- PLAYING, goals:
  - Any goal_valid bit set: every set bit increments its team's score, saturating at 2^SCORE_WIDTH-1.
  - Scores update the cycle after goal_valid.
  - If any updated score >= WIN_SCORE (WIN_SCORE != 0) -> OVER.
  - Otherwise -> GOAL_HOLD, with ball_reset pulsed for exactly 1 cycle on entry.
- PLAYING, simultaneous events:
  - Goal and final second wrap in the same cycle: the goal is credited, time_left still decrements to 0, next state is OVER, no ball_reset.
  - pause_pulse together with a goal: the goal has priority and the pause is dropped.
  - pause_pulse alone -> PAUSED.
- PAUSED:
  - Prescaler and time_left frozen; goals ignored.
  - pause_pulse -> PLAYING, prescaler value retained.
  - start_pulse is ignored.
- GOAL_HOLD:
  - Hold counter counts GOAL_HOLD_SECONDS*CLK_FREQ_HZ cycles, then -> PLAYING.
  - Countdown frozen; goals and pause ignored.
  - GOAL_HOLD_SECONDS=0 returns to PLAYING after 1 cycle.
- OVER:
  - winner/draw are registered on the entry cycle and held.
  - winner = lowest index with the maximum score.
  - draw = 1 if two or more teams share the maximum.
  - start_pulse clears scores, reloads time_left -> IDLE.
- game_on and game_over are decoded from registered state; no glitches.
- time_left never underflows.

Optional Feature:
- Macro: MATCH_CONTROLLER_GOLDEN_GOAL_EN.
- Defined, time expiry with a draw:
  - -> OVERTIME instead of OVER; time_left stays 0 and sec_tick is silent.
  - The first goal credited in OVERTIME -> OVER with a unique winner.
  - Pause is ignored in OVERTIME.
  - Simultaneous goals in OVERTIME credit all set bits; if the result is still a draw, stay in OVERTIME and pulse ball_reset.
- Undefined: OVERTIME is unreachable and a draw at expiry -> OVER with draw=1.

Decomposition:
- Shared package match_pkg holds:
  - the state enum (3-bit encodings above);
  - the TIME_W / winner-width clog2 helper function;
  - the packed score slice helper.
- Sub-module sec_prescaler:
  - inputs: clk, rst, en, clr;
  - output: one-cycle tick;
  - parameter: DIV=CLK_FREQ_HZ.
- sec_prescaler is reused for the goal-hold counter via a second instance with DIV=GOAL_HOLD_SECONDS*CLK_FREQ_HZ.

Test Plan (all scenarios use CLK_FREQ_HZ=4, MATCH_SECONDS=3, NUM_TEAMS=2, SCORE_WIDTH=3, WIN_SCORE=3, GOAL_HOLD_SECONDS=1):
- Full countdown: rst, then start_pulse -> PLAYING; sec_tick every 4 cycles; time_left 3,2,1,0; OVER 12 cycles after PLAYING entry; draw=1, winner=0.
- Goal path: goal_valid=2'b10 in PLAYING -> scores={1,0} (team1=1) next cycle; ball_reset pulses once; GOAL_HOLD lasts 4 cycles; time_left unchanged during hold.
- Win-by-score: three team0 goals -> after the third, state=OVER immediately; winner=0, draw=0; no ball_reset on the third goal.
- Pause: pause_pulse at prescaler=2 -> PAUSED; 20 cycles idle, time_left frozen; pause_pulse -> resume; next sec_tick arrives 2 cycles later.
- Simultaneous events: goal_valid=2'b11 on the final wrap cycle -> scores {1,1}, time_left=0, OVER, draw=1. With MATCH_CONTROLLER_GOLDEN_GOAL_EN the same stimulus gives OVERTIME; a later goal_valid=2'b01 -> OVER, winner=0.
- Restart and reset: start_pulse in OVER -> IDLE with scores=0 and time_left=3. Separately, rst asserted mid-GOAL_HOLD -> IDLE with every output at its reset value on the next cycle.
